mem_port_arbiter: RTL and testbench

- Shares the single-port system memory bus between the instruction-fetch port (I) and the MEM-stage load/store port (D).
- Data accesses have priority because they belong to older instructions. A starvation guard periodically forces an instruction grant.
- Returns per-port completion pulses, which the pipeline-control logic turns into stall/flush for the IF/ID and EX/MEM registers.
- Includes a bus watchdog and fetch-kill on branch flush.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port memory bus, shared by instruction fetch (I) and load/store (D).
// D has priority; a starvation guard forces an I grant. Includes a bus watchdog and fetch kill.
module mem_port_arbiter #(
  parameter int TIMEOUT      = 64,
  parameter int D_MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [3:0] CONSEC_MAX = 4'(D_MAX_CONSEC);

  logic [1:0] state;
  logic [3:0] consec;
  logic [7:0] tmo;
  logic       kill;

  logic i_valid;
  logic d_valid;
  logic guard;
  logic grant_d;
  logic grant_i;
  logic expired;

  // Arbitration: a port whose ready pulse is high this cycle is not re-granted.
  always_comb begin
    i_valid = i_req && !i_ready;
    d_valid = d_req && !d_ready;
    guard   = i_valid && (consec == CONSEC_MAX);
    grant_d = 1'b0;
    grant_i = 1'b0;
    expired = 1'b0;
    if (state == S_IDLE) begin
      grant_d = d_valid && !guard;
      grant_i = !grant_d && i_valid && !i_flush;
    end else begin
      expired = !bus_ack && (tmo == TMO_LAST);
    end
  end

  // Main FSM, bus registers, completion pulses and watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tmo       <= 8'd0;
      kill      <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_wstrb <= 4'd0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      i_ready   <= 1'b0;
      i_rdata   <= 32'd0;
      i_err     <= 1'b0;
      d_ready   <= 1'b0;
      d_rdata   <= 32'd0;
      d_err     <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      i_err   <= 1'b0;
      d_ready <= 1'b0;
      d_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          kill <= 1'b0;
          tmo  <= 8'd0;
          if (grant_d) begin
            state     <= S_BUSY_D;
            bus_req   <= 1'b1;
            bus_we    <= d_we;
            bus_wstrb <= d_wstrb;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
          end else if (grant_i) begin
            state     <= S_BUSY_I;
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'd0;
            bus_addr  <= i_addr;
            bus_wdata <= 32'd0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY_I: begin
          if (bus_ack || expired) begin
            state   <= S_IDLE;
            bus_req <= 1'b0;
            kill    <= 1'b0;
            // A flush in the completing cycle also suppresses the result.
            if (!kill && !i_flush) begin
              i_ready <= 1'b1;
              i_err   <= !bus_ack;
              i_rdata <= bus_ack ? bus_rdata : 32'd0;
            end
          end else begin
            tmo <= tmo + 8'd1;
            if (i_flush) begin
              kill <= 1'b1;
            end
          end
        end
        S_BUSY_D: begin
          if (bus_ack || expired) begin
            state   <= S_IDLE;
            bus_req <= 1'b0;
            d_ready <= 1'b1;
            d_err   <= !bus_ack;
            d_rdata <= (bus_ack && !bus_we) ? bus_rdata : 32'd0;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  // Starvation counter: consecutive D grants while a fetch is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      consec <= 4'd0;
    end else if (!i_req || grant_i) begin
      consec <= 4'd0;
    end else if (grant_d && (consec != CONSEC_MAX)) begin
      consec <= consec + 4'd1;
    end else begin
      consec <= consec;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small delayed-ack memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_flush, i_ready, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready, d_err;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  logic        ack_en;
  int          ack_delay;
  int          bcnt;
  int          checks   = 0;
  int          failures = 0;

  mem_port_arbiter #(.TIMEOUT(64), .D_MAX_CONSEC(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Memory: acks in the (ack_delay+1)-th cycle of bus_req.
  assign bus_ack = ack_en && bus_req && (bcnt == ack_delay);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bcnt <= 0;
    else if (bus_req && !bus_ack) bcnt <= bcnt + 1;
    else bcnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = 32'd0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'd0; d_addr = 32'd0; d_wdata = 32'd0;
    ack_en = 1'b1; ack_delay = 0; bus_rdata = 32'd0;
    step(); step();
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_readys", {30'd0, i_ready, d_ready}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;
    step();

    // Single load, ack in first bus_req cycle
    bus_rdata = 32'hDEADBEEF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    step();
    check("ld_bus_req", {31'd0, bus_req}, 32'd1);
    check("ld_bus_addr", bus_addr, 32'h100);
    check("ld_bus_we", {31'd0, bus_we}, 32'd0);
    check("ld_no_early_ready", {31'd0, d_ready}, 32'd0);
    step();
    check("ld_d_ready", {31'd0, d_ready}, 32'd1);
    check("ld_d_rdata", d_rdata, 32'hDEADBEEF);
    check("ld_d_err", {31'd0, d_err}, 32'd0);
    check("ld_bus_req_drop", {31'd0, bus_req}, 32'd0);
    d_req = 1'b0;
    step();
    check("ld_ready_single", {31'd0, d_ready}, 32'd0);

    // Store with ack in the third bus_req cycle; inputs change while busy
    ack_delay = 2; bus_rdata = 32'hCAFEF00D;
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0011; d_addr = 32'h104; d_wdata = 32'h12345678;
    step();
    d_addr = 32'hFFFF_0000; d_wdata = 32'h0; d_wstrb = 4'hF;
    for (int k = 0; k < 3; k++) begin
      check("st_bus_req", {31'd0, bus_req}, 32'd1);
      check("st_bus_addr", bus_addr, 32'h104);
      check("st_bus_wdata", bus_wdata, 32'h12345678);
      check("st_bus_ctl", {27'd0, bus_we, bus_wstrb}, {27'd0, 1'b1, 4'b0011});
      check("st_no_ready", {31'd0, d_ready}, 32'd0);
      step();
    end
    check("st_d_ready", {31'd0, d_ready}, 32'd1);
    check("st_d_rdata", d_rdata, 32'd0);
    check("st_bus_req_drop", {31'd0, bus_req}, 32'd0);
    d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'd0;
    step();

    // Starvation guard: I blocked by flush while D is granted 4 times
    ack_delay = 0; bus_rdata = 32'h11112222;
    d_addr = 32'h200; i_addr = 32'h3000;
    d_req = 1'b1; i_req = 1'b1; i_flush = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("sv_d_grant", bus_addr, 32'h200);
      check("sv_d_busy", {31'd0, bus_req}, 32'd1);
      step();
      check("sv_d_ready", {31'd0, d_ready}, 32'd1);
      step();
    end
    step();
    check("sv_guard_blocks_d", {31'd0, bus_req}, 32'd0);
    i_flush = 1'b0;
    step();
    check("sv_i_forced", bus_addr, 32'h3000);
    check("sv_i_busy", {31'd0, bus_req}, 32'd1);
    check("sv_i_we", {27'd0, bus_we, bus_wstrb}, 32'd0);
    step();
    check("sv_i_ready", {31'd0, i_ready}, 32'd1);
    check("sv_i_rdata", i_rdata, 32'h11112222);
    step();
    check("sv_d_after_i", bus_addr, 32'h200);
    check("sv_d_after_i_req", {31'd0, bus_req}, 32'd1);
    step();
    check("sv_d_ready2", {31'd0, d_ready}, 32'd1);
    d_req = 1'b0; i_req = 1'b0;
    step();

    // Watchdog: no ack, bus_req held 64 cycles then error completion
    ack_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    step();
    for (int k = 1; k < 64; k++) step();
    check("to_bus_req_c64", {31'd0, bus_req}, 32'd1);
    check("to_no_early_ready", {31'd0, d_ready}, 32'd0);
    step();
    check("to_bus_req_drop", {31'd0, bus_req}, 32'd0);
    check("to_d_ready", {31'd0, d_ready}, 32'd1);
    check("to_d_err", {31'd0, d_err}, 32'd1);
    check("to_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    step();
    check("to_err_pulse", {31'd0, d_err}, 32'd0);

    // Ack on the 64th busy cycle wins over the watchdog
    ack_en = 1'b1; ack_delay = 63; bus_rdata = 32'h0BADCAFE;
    d_req = 1'b1; d_addr = 32'h304;
    step();
    for (int k = 1; k < 64; k++) step();
    check("ta_bus_req_c64", {31'd0, bus_req}, 32'd1);
    step();
    check("ta_d_ready", {31'd0, d_ready}, 32'd1);
    check("ta_d_err", {31'd0, d_err}, 32'd0);
    check("ta_d_rdata", d_rdata, 32'h0BADCAFE);
    d_req = 1'b0;
    step();

    // Fetch killed by flush during BUSY_I; bus transfer still completes
    ack_delay = 1; bus_rdata = 32'hAAAA5555;
    i_req = 1'b1; i_addr = 32'h2000;
    step();
    check("fl_bus_addr", bus_addr, 32'h2000);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0; i_req = 1'b0;
    check("fl_bus_req_held", {31'd0, bus_req}, 32'd1);
    step();
    check("fl_bus_done", {31'd0, bus_req}, 32'd0);
    check("fl_no_i_ready", {31'd0, i_ready}, 32'd0);
    check("fl_i_rdata_hold", i_rdata, 32'h11112222);
    step();
    check("fl_no_i_ready_late", {31'd0, i_ready}, 32'd0);
    ack_delay = 0; bus_rdata = 32'h33334444;
    i_req = 1'b1; i_addr = 32'h3000;
    step();
    check("fl_next_addr", bus_addr, 32'h3000);
    step();
    check("fl_next_ready", {31'd0, i_ready}, 32'd1);
    check("fl_next_rdata", i_rdata, 32'h33334444);
    check("fl_next_err", {31'd0, i_err}, 32'd0);
    i_req = 1'b0;
    step();

    // Reset in the middle of BUSY_D
    ack_en = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF; d_addr = 32'h400; d_wdata = 32'h55;
    step();
    check("rm_busy", {31'd0, bus_req}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rm_bus_req", {31'd0, bus_req}, 32'd0);
    check("rm_bus_ctl", {27'd0, bus_we, bus_wstrb}, 32'd0);
    check("rm_bus_addr", bus_addr, 32'd0);
    check("rm_d_ready", {31'd0, d_ready}, 32'd0);
    step();
    reset = 1'b0;
    ack_en = 1'b1; ack_delay = 0; d_we = 1'b0; bus_rdata = 32'h600D600D;
    step();
    check("rm_regrant", bus_addr, 32'h400);
    check("rm_regrant_req", {31'd0, bus_req}, 32'd1);
    step();
    check("rm_d_ready", {31'd0, d_ready}, 32'd1);
    check("rm_d_rdata", d_rdata, 32'h600D600D);
    d_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
